serial_rx_block: RTL

//  Receive side of the serial link fed by the parallel-to-serial transmitter. Line idles high.

---
 rtl/serial_rx_block.sv | 106 ++++++++++
 1 files changed

// File: rtl/serial_rx_block.sv
// Serial line receiver: synchronise, find start bit, sample mid-bit, deserialise, hold word.
// Latency: data_ready rises 97 clocks after the start edge (8 bits, 10 clk/bit); one-word buffer, overrun flagged.
module serial_rx_block #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter bit SHIFT_MSB    = 1'b1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] B_LAST = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, LOAD} state_t;

  state_t               state;
  logic                 sync1, sync2, prev;
  logic [TW-1:0]        timer;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 start_edge;
  logic                 strobe;

  assign start_edge = !sync2 && prev;
  assign strobe     = (timer == T_HALF);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= serial_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      timer         <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      rx_data       <= '1;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      timer <= (timer == T_LAST) ? '0 : timer + TW'(1);
      if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
      case (state)
        IDLE: begin
          // timer reads 0 during the edge cycle, so strobes land at E+CLKS_PER_BIT/2
          timer <= start_edge ? TW'(1) : '0;
          if (start_edge) state <= START;
        end
        START: if (strobe) begin
          if (!sync2) begin
            state         <= DATA;
            bit_cnt       <= '0;
            framing_error <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: if (strobe) begin
          if (SHIFT_MSB) shift_reg <= {shift_reg[DATA_BITS-2:0], sync2};
          else           shift_reg <= {sync2, shift_reg[DATA_BITS-1:1]};
          if (bit_cnt == B_LAST) state <= STOP;
          else                   bit_cnt <= bit_cnt + CW'(1);
        end
        STOP: if (strobe) begin
          // leaving mid stop bit leaves half a bit to catch a back-to-back start edge
          if (sync2) begin
            state <= LOAD;
          end else begin
            framing_error <= 1'b1;
            state         <= IDLE;
          end
        end
        LOAD: begin
          rx_data    <= shift_reg;
          data_ready <= 1'b1;
          if (data_ready && !data_read) overrun_error <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
